// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: segment patterns {a..g} (bit6=a)
// and the frame-collection FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    typedef enum logic {HUNT, COLLECT} state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational segment-pattern decoder. Letters A-F are recognised only when
// HEX_DECODE_EN is defined; otherwise they are flagged as illegal like any unknown pattern.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       err
);

    always_comb begin
        value = 4'h0;
        err   = 1'b0;
        case (seg)
            SEG_0: value = 4'h0;
            SEG_1: value = 4'h1;
            SEG_2: value = 4'h2;
            SEG_3: value = 4'h3;
            SEG_4: value = 4'h4;
            SEG_5: value = 4'h5;
            SEG_6: value = 4'h6;
            SEG_7: value = 4'h7;
            SEG_8: value = 4'h8;
            SEG_9: value = 4'h9;
`ifdef HEX_DECODE_EN
            SEG_A: value = 4'hA;
            SEG_B: value = 4'hB;
            SEG_C: value = 4'hC;
            SEG_D: value = 4'hD;
            SEG_E: value = 4'hE;
            SEG_F: value = 4'hF;
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers one 4-bit value per digit from a multiplexed 7-segment bus and presents whole
// frames over valid/ready. Optional letter decoding via HEX_DECODE_EN (see seg7_to_hex).
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     an,
    output logic [4*NDIG-1:0]   out_digits,
    output logic [NDIG-1:0]     out_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t            state;
    logic [NDIG+6:0]   prev_in;
    logic [SW-1:0]     stab_cnt;
    logic [SW-1:0]     stab_next;
    logic [TW-1:0]     tcnt;
    logic [NDIG-1:0]   mask;
    logic [4*NDIG-1:0] stage_digits;
    logic [NDIG-1:0]   stage_err;
    logic [4*NDIG-1:0] merged_digits;
    logic [NDIG-1:0]   merged_err;
    logic [IW-1:0]     idx;
    logic [3:0]        dec_value;
    logic              dec_err;
    logic              an_onehot;
    logic              stable;
    logic              capture;
    logic              full;
    logic              handshake;

    seg7_to_hex u_dec (
        .seg   (seg),
        .value (dec_value),
        .err   (dec_err)
    );

    // The counter saturates one past the trigger value so each dwell fires exactly once.
    always_comb begin
        an_onehot = $onehot(an);
        stab_next = '0;
        if (an_onehot && ({an, seg} == prev_in)) begin
            stab_next = (stab_cnt == SW'(STABLE_CYC)) ? stab_cnt : stab_cnt + SW'(1);
        end
        stable    = an_onehot && (stab_next == SW'(STABLE_CYC - 1));
        capture   = stable && ((state == COLLECT) || an[0]);
        full      = capture && ((mask | an) == '1);
        handshake = out_valid && out_ready;
    end

    // Staging view with the digit being captured this cycle already merged in, so a
    // completing capture can go straight to the output registers.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (an[i]) idx = IW'(i);
        end
        merged_digits              = stage_digits;
        merged_err                 = stage_err;
        merged_digits[idx*4 +: 4]  = dec_value;
        merged_err[idx]            = dec_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HUNT;
            prev_in      <= '0;
            stab_cnt     <= '0;
            tcnt         <= '0;
            mask         <= '0;
            stage_digits <= '0;
            stage_err    <= '0;
            out_digits   <= '0;
            out_err      <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            prev_in  <= {an, seg};
            stab_cnt <= stab_next;
            if (handshake) out_valid <= 1'b0;

            if (capture) begin
                stage_digits <= merged_digits;
                stage_err    <= merged_err;
                tcnt         <= '0;
                if (full) begin
                    out_digits <= merged_digits;
                    out_err    <= merged_err;
                    out_valid  <= 1'b1;
                    if (out_valid && !out_ready) overrun <= 1'b1;
                    mask       <= '0;
                    state      <= HUNT;
                end else begin
                    mask  <= mask | an;
                    state <= COLLECT;
                end
            end else if (state == COLLECT) begin
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    tcnt  <= '0;
                    mask  <= '0;
                    state <= HUNT;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scan scenarios plus random dwells, every cycle
// compared against a frame-level reference model. Honours HEX_DECODE_EN.
module tb_seg7_scan_reader;

    localparam int NDIG        = 4;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 1024;

    localparam logic [6:0] CODES [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] out_digits;
    logic [NDIG-1:0]   out_err;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;

    int tests = 0;
    int fails = 0;

    // Reference model: run length of the current bus value, digits seen this frame, idle time.
    logic [NDIG+6:0]   m_prev;
    int                m_run;
    bit                m_collect;
    logic [NDIG-1:0]   m_seen;
    logic [3:0]        m_val [NDIG];
    logic              m_errv [NDIG];
    int                m_idle;
    logic [4*NDIG-1:0] m_digits;
    logic [NDIG-1:0]   m_err;
    bit                m_valid;
    bit                m_overrun;

    int                pulses;
    logic [15:0]       last_digits;
    logic [3:0]        last_err;

    always #5 clk = ~clk;

    seg7_scan_reader #(
        .NDIG        (NDIG),
        .STABLE_CYC  (STABLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .an         (an),
        .out_digits (out_digits),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] refDecode(input logic [6:0] s);
        int legal;
`ifdef HEX_DECODE_EN
        legal = 16;
`else
        legal = 10;
`endif
        for (int k = 0; k < legal; k++) begin
            if (s == CODES[k]) return {1'b0, 4'(k)};
        end
        return 5'b1_0000;
    endfunction

    task automatic modelReset();
        m_prev    = '0;
        m_run     = 0;
        m_collect = 0;
        m_seen    = '0;
        m_idle    = 0;
        m_digits  = '0;
        m_err     = '0;
        m_valid   = 0;
        m_overrun = 0;
        for (int k = 0; k < NDIG; k++) begin
            m_val[k]  = 4'h0;
            m_errv[k] = 1'b0;
        end
    endtask

    task automatic modelStep();
        bit          hs;
        bit          oh;
        bit          transfer;
        logic [4:0]  d;
        hs       = m_valid && out_ready;
        oh       = ($countones(an) == 1);
        transfer = 0;
        if (oh && ({an, seg} == m_prev)) m_run++;
        else m_run = oh ? 1 : 0;
        m_prev = {an, seg};
        if (oh && m_run == STABLE_CYC && (m_collect || an[0])) begin
            d = refDecode(seg);
            for (int k = 0; k < NDIG; k++) begin
                if (an[k]) begin
                    m_val[k]  = d[3:0];
                    m_errv[k] = d[4];
                    m_seen[k] = 1'b1;
                end
            end
            m_idle = 0;
            if (&m_seen) begin
                transfer  = 1;
                m_seen    = '0;
                m_collect = 0;
            end else begin
                m_collect = 1;
            end
        end else if (m_collect) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYC) begin
                m_collect = 0;
                m_seen    = '0;
                m_idle    = 0;
            end
        end
        if (transfer) begin
            if (m_valid && !hs) m_overrun = 1;
            m_valid = 1;
            for (int k = 0; k < NDIG; k++) begin
                m_digits[4*k +: 4] = m_val[k];
                m_err[k]           = m_errv[k];
            end
        end else if (hs) begin
            m_valid = 0;
        end
    endtask

    task automatic driveCycle(input logic [NDIG-1:0] a, input logic [6:0] s, input logic r);
        an        = a;
        seg       = s;
        out_ready = r;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("outs", 32'({out_valid, overrun, out_err, out_digits}),
                    32'({m_valid, m_overrun, m_err, m_digits}));
        if (out_valid) begin
            pulses++;
            last_digits = out_digits;
            last_err    = out_err;
        end
    endtask

    // rmode: 0 = ready low, 1 = ready high, 2 = random ready each cycle
    task automatic applyStimulus(input logic [NDIG-1:0] a, input logic [6:0] s, input int n,
                                 input int rmode);
        for (int c = 0; c < n; c++) begin
            driveCycle(a, s, (rmode == 2) ? ($urandom % 4 != 0) : (rmode == 1));
        end
    endtask

    task automatic scanFrame(input logic [27:0] pats, input int n, input int rmode);
        for (int i = 0; i < NDIG; i++) begin
            applyStimulus(4'(1 << i), pats[7*i +: 7], n, rmode);
        end
    endtask

    task automatic doReset();
        an        = '0;
        seg       = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput("reset_outs", 32'({out_valid, overrun, out_err, out_digits}), 32'h0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [NDIG-1:0] ra;
        logic [6:0]      rs;
        an        = '0;
        seg       = '0;
        out_ready = 1'b0;
        pulses    = 0;
        #2;
        doReset();

        // Plain scan 1,2,3,4 with the consumer always ready
        pulses = 0;
        scanFrame({7'h33, 7'h79, 7'h6D, 7'h30}, 8, 1);
        applyStimulus('0, 7'h00, 3, 1);
        checkOutput("s1_digits", 32'(last_digits), 32'h4321);
        checkOutput("s1_err", 32'(last_err), 32'h0);
        checkOutput("s1_pulses", 32'(pulses), 32'd1);

        // Digit 2 settles late; then 3-cycle dwells must never capture
        pulses = 0;
        applyStimulus(4'b0001, 7'h30, 8, 1);
        applyStimulus(4'b0010, 7'h6D, 8, 1);
        applyStimulus(4'b0100, 7'h7F, 2, 1);
        applyStimulus(4'b0100, 7'h7B, 8, 1);
        applyStimulus(4'b1000, 7'h33, 8, 1);
        checkOutput("s2_digits", 32'(last_digits), 32'h4921);
        checkOutput("s2_pulses", 32'(pulses), 32'd1);
        pulses = 0;
        scanFrame({7'h33, 7'h79, 7'h6D, 7'h30}, 3, 1);
        scanFrame({7'h33, 7'h79, 7'h6D, 7'h30}, 3, 1);
        applyStimulus('0, 7'h00, 4, 1);
        checkOutput("s2_short_dwell", 32'(pulses), 32'd0);

        // Flicker and multi-hot enables stall digit 3's predecessor until the frame times out
        pulses = 0;
        applyStimulus(4'b0001, 7'h30, 8, 1);
        applyStimulus(4'b0010, 7'h6D, 8, 1);
        applyStimulus(4'b0100, 7'h79, 8, 1);
        applyStimulus(4'b0011, 7'h30, 20, 1);
        for (int c = 0; c < 540; c++) begin
            driveCycle(4'b0010, 7'h7F, 1'b1);
            driveCycle(4'b0010, 7'h5F, 1'b1);
        end
        applyStimulus(4'b1000, 7'h33, 8, 1);
        checkOutput("s3_timeout", 32'(pulses), 32'd0);

        // Letter pattern on digit 3
        pulses = 0;
        scanFrame({7'h77, 7'h79, 7'h6D, 7'h30}, 8, 1);
`ifdef HEX_DECODE_EN
        checkOutput("s4_digits", 32'(last_digits), 32'hA321);
        checkOutput("s4_err", 32'(last_err), 32'h0);
`else
        checkOutput("s4_digits", 32'(last_digits), 32'h0321);
        checkOutput("s4_err", 32'(last_err), 32'h8);
`endif

        // Two unread frames, then reset in the middle of a third
        doReset();
        scanFrame({7'h33, 7'h79, 7'h6D, 7'h30}, 8, 0);
        scanFrame({7'h30, 7'h6D, 7'h79, 7'h33}, 8, 0);
        checkOutput("s5_overrun", 32'(overrun), 32'd1);
        checkOutput("s5_digits", 32'(out_digits), 32'h1234);
        checkOutput("s5_valid", 32'(out_valid), 32'd1);
        applyStimulus(4'b0001, 7'h7E, 8, 0);
        applyStimulus(4'b0010, 7'h30, 5, 0);
        doReset();

        // Handshake lands on the very edge that transfers frame 2
        scanFrame({7'h33, 7'h79, 7'h6D, 7'h30}, 8, 0);
        applyStimulus(4'b0001, 7'h33, 8, 0);
        applyStimulus(4'b0010, 7'h79, 8, 0);
        applyStimulus(4'b0100, 7'h6D, 8, 0);
        applyStimulus(4'b1000, 7'h30, 3, 0);
        driveCycle(4'b1000, 7'h30, 1'b1);
        applyStimulus(4'b1000, 7'h30, 4, 0);
        checkOutput("s6_overrun", 32'(overrun), 32'd0);
        checkOutput("s6_valid", 32'(out_valid), 32'd1);
        checkOutput("s6_digits", 32'(out_digits), 32'h1234);

        // Random dwells with random consumer back-pressure
        doReset();
        for (int d = 0; d < 300; d++) begin
            case ($urandom % 10)
                0:       ra = '0;
                1:       ra = 4'($urandom);
                default: ra = 4'(1 << ($urandom % NDIG));
            endcase
            rs = ($urandom % 3 == 0) ? 7'($urandom) : CODES[$urandom % 16];
            applyStimulus(ra, rs, 1 + int'($urandom % 9), 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
